// File: rtl/i2s_tx_8ch.sv
// 8-channel I2S transmitter: double-buffers one ch0..ch7 frame from a ready/valid
// stream and serializes it as four stereo I2S lanes sharing one bck/lrck pair.
module i2s_tx_8ch #(
  parameter int SAMPLE_BITS = 24,
  parameter int SLOT_BITS   = 32,
  parameter int BCK_DIV     = 2
) (
  input  logic                   mclk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [SAMPLE_BITS-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   bck,
  output logic                   lrck,
  output logic [3:0]             sdata,
  output logic                   frame_start,
  output logic                   underrun
);

  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] K_LAST   = BIT_W'(SAMPLE_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);

  logic [SAMPLE_BITS-1:0] entry [8];
  logic [SAMPLE_BITS-1:0] shreg [8];
  logic [3:0]             count;
  logic [DIV_W-1:0]       div;
  logic [BIT_W-1:0]       bit_cnt;
  logic                   active;

  logic             handshake, frame_full, tc, fall_edge, boundary;
  logic             right_nxt, data_bit;
  logic [BIT_W-1:0] bit_nxt, slot_k;

  assign in_ready   = (count < 4'd8);
  assign handshake  = in_valid && in_ready;
  assign frame_full = (count == 4'd8);
  assign tc         = (div == DIV_LAST);
  assign fall_edge  = active && tc && bck;
  // The first enabled cycle after idle counts as a frame boundary so the link
  // always starts at bit 0 with a fresh transfer decision.
  assign boundary   = enable && (!active || (fall_edge && bit_cnt == BIT_LAST));
  assign bit_nxt    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
  assign right_nxt  = (bit_nxt >= SLOT_LEN);
  assign slot_k     = right_nxt ? bit_nxt - SLOT_LEN : bit_nxt;
  assign data_bit   = (slot_k >= BIT_W'(1)) && (slot_k <= K_LAST);

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      for (int c = 0; c < 8; c++) entry[c] <= '0;
    end else if (boundary && frame_full) begin
      count <= '0;
    end else if (handshake) begin
      entry[count[2:0]] <= in_data;
      count             <= count + 4'd1;
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      active      <= 1'b0;
      div         <= '0;
      bit_cnt     <= '0;
      bck         <= 1'b0;
      lrck        <= 1'b0;
      sdata       <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      for (int c = 0; c < 8; c++) shreg[c] <= '0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (!enable) begin
        active  <= 1'b0;
        div     <= '0;
        bit_cnt <= '0;
        bck     <= 1'b0;
        lrck    <= 1'b0;
        sdata   <= '0;
        for (int c = 0; c < 8; c++) shreg[c] <= '0;
      end else begin
        if (!active) begin
          active  <= 1'b1;
          div     <= '0;
          bck     <= 1'b0;
          bit_cnt <= '0;
          lrck    <= 1'b0;
        end else begin
          div <= tc ? '0 : div + 1'b1;
          if (tc) bck <= ~bck;
          if (fall_edge) begin
            bit_cnt <= bit_nxt;
            lrck    <= right_nxt;
          end
        end
        if (boundary) begin
          frame_start <= 1'b1;
          underrun    <= !frame_full;
          sdata       <= '0;
          for (int c = 0; c < 8; c++) shreg[c] <= frame_full ? entry[c] : '0;
        end else if (fall_edge) begin
          // Only the channel of the slot being sent shifts; the other waits its turn.
          for (int n = 0; n < 4; n++) begin
            if (data_bit) begin
              sdata[n]                         <= shreg[2*n + int'(right_nxt)][SAMPLE_BITS-1];
              shreg[2*n + int'(right_nxt)]     <= shreg[2*n + int'(right_nxt)] << 1;
            end else begin
              sdata[n] <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule
